seg_box_overlay: RTL and testbench

- Consumer of the projection segmenter's boundary outputs: 8 horizontal segment pairs (left/right) plus one vertical pair (top/bottom).
- Draws up to 8 rectangular outlines onto the 24-bit RGB display stream, one per segmented character.
- Bounds are shadow-latched once per frame so every box is drawn frame-consistently.
- Sits after the segmenter, in parallel with the video path, and before the HDMI/VGA output encoder.

---
 rtl/seg_box_overlay.sv | 186 ++++++++++++++++++
 tb/tb_seg_box_overlay.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_box_overlay.sv
// seg_box_overlay: draws up to eight rectangular outlines onto the RGB stream.
// Box bounds come from the projection segmenter. They are shadow-latched on
// each vs rise so every box stays consistent for the whole frame.
module seg_box_overlay #(
    parameter int                        IMG_WIDTH_LINE = 1920,
    parameter int                        IMG_WIDTH_DATA = 24,
    parameter int                        THICK          = 2,
    parameter logic [IMG_WIDTH_DATA-1:0] BOX_COLOR      = 24'hFF0000
) (
    input  logic                      pixelclk,
    input  logic                      reset_n,
    input  logic [IMG_WIDTH_DATA-1:0] i_rgb,
    input  logic                      i_hs,
    input  logic                      i_vs,
    input  logic                      i_de,
    input  logic [191:0]              i_hbound,
    input  logic [11:0]               i_vcount_l,
    input  logic [11:0]               i_vcount_r,
    input  logic                      i_overlay_en,
    output logic [IMG_WIDTH_DATA-1:0] o_rgb,
    output logic                      o_hs,
    output logic                      o_vs,
    output logic                      o_de,
    output logic [11:0]               o_hcount,
    output logic [11:0]               o_vcount,
    output logic [3:0]                o_box_cnt
);

    localparam logic [11:0] HMAX = 12'(IMG_WIDTH_LINE - 1);
    localparam logic [12:0] TKM1 = 13'(THICK - 1);

    // Column counter step that holds at the last active column.
    function automatic logic [11:0] sat_inc(input logic [11:0] c);
        return (c >= HMAX) ? c : c + 12'd1;
    endfunction

    // Number of valid boxes in a shadow set.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    logic                      r_vs_d, r_de_d;
    logic [11:0]               r_hcnt, r_vcnt;
    logic [191:0]              r_hb_sh;
    logic [11:0]               r_vl_sh, r_vr_sh;
    logic [7:0]                r_valid_sh;
    logic                      r_en_sh;
    logic [3:0]                r_box_cnt;
    logic                      w_vs_rise, w_de_fall;
    logic [7:0]                w_valid_in;
    logic [7:0]                w_edge_p0;
    logic [7:0]                r_edge_p1;
    logic [IMG_WIDTH_DATA-1:0] r_rgb_p1, r_rgb_p2;
    logic                      r_vld_p1, r_vld_p2;
    logic                      r_hs_p1, r_hs_p2, r_vs_p1, r_vs_p2;
    logic [11:0]               r_hcnt_p1, r_hcnt_p2, r_vcnt_p1, r_vcnt_p2;
    logic                      w_hit_p1;

    assign w_vs_rise = i_vs & ~r_vs_d;
    assign w_de_fall = r_de_d & ~i_de;

    // Edge-detect history for the vs rise and the de fall.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_d <= 1'b0;
            r_de_d <= 1'b0;
        end else begin
            r_vs_d <= i_vs;
            r_de_d <= i_de;
        end
    end

    // Active-pixel position of the pixel currently on the inputs.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            r_hcnt <= i_de ? sat_inc(r_hcnt) : 12'd0;
            if (w_vs_rise)      r_vcnt <= '0;
            else if (w_de_fall) r_vcnt <= r_vcnt + 12'd1;
        end
    end

    // A box is usable only if it has positive width and height.
    always_comb begin
        w_valid_in = '0;
        for (int k = 0; k < 8; k++)
            w_valid_in[k] = (i_hbound[24*k+12 +: 12] > i_hbound[24*k +: 12]) &&
                            (i_vcount_r > i_vcount_l);
    end

    // Shadow set, captured only on the vs rise. All other input changes are ignored.
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_hb_sh    <= '0;
            r_vl_sh    <= '0;
            r_vr_sh    <= '0;
            r_valid_sh <= '0;
            r_en_sh    <= 1'b0;
            r_box_cnt  <= '0;
        end else if (w_vs_rise) begin
            r_hb_sh    <= i_hbound;
            r_vl_sh    <= i_vcount_l;
            r_vr_sh    <= i_vcount_r;
            r_valid_sh <= w_valid_in;
            r_en_sh    <= i_overlay_en;
            r_box_cnt  <= popcount8(w_valid_in);
        end
    end

    // Per-box border hit. Edge bands are only meaningful inside the rectangle.
    // 13-bit math keeps l+THICK-1 and hcnt+THICK-1 from wrapping at the top of range.
    always_comb begin : p_hit
        logic [12:0] l, r, h, v, vl, vr;
        logic        in_h, in_v, near_l_r, near_t_b;
        w_edge_p0 = '0;
        h  = {1'b0, r_hcnt};
        v  = {1'b0, r_vcnt};
        vl = {1'b0, r_vl_sh};
        vr = {1'b0, r_vr_sh};
        for (int k = 0; k < 8; k++) begin
            l        = {1'b0, r_hb_sh[24*k +: 12]};
            r        = {1'b0, r_hb_sh[24*k+12 +: 12]};
            in_h     = (h >= l) && (h <= r);
            in_v     = (v >= vl) && (v <= vr);
            near_l_r = (h <= l + TKM1) || (h + TKM1 >= r);
            near_t_b = (v <= vl + TKM1) || (v + TKM1 >= vr);
            w_edge_p0[k] = r_valid_sh[k] && in_h && in_v && (near_l_r || near_t_b);
        end
    end

    // ---- stage 1: register per-box hits alongside the delayed video ----
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_p1 <= '0;
            r_rgb_p1  <= '0;
            r_vld_p1  <= 1'b0;
            r_hs_p1   <= 1'b0;
            r_vs_p1   <= 1'b0;
            r_hcnt_p1 <= '0;
            r_vcnt_p1 <= '0;
        end else begin
            r_edge_p1 <= w_edge_p0;
            r_rgb_p1  <= i_rgb;
            r_vld_p1  <= i_de;
            r_hs_p1   <= i_hs;
            r_vs_p1   <= i_vs;
            r_hcnt_p1 <= r_hcnt;
            r_vcnt_p1 <= r_vcnt;
        end
    end

    assign w_hit_p1 = r_en_sh & (|r_edge_p1) & r_vld_p1;

    // ---- stage 2: merge hits and select border colour or passthrough ----
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            r_rgb_p2  <= '0;
            r_vld_p2  <= 1'b0;
            r_hs_p2   <= 1'b0;
            r_vs_p2   <= 1'b0;
            r_hcnt_p2 <= '0;
            r_vcnt_p2 <= '0;
        end else begin
            r_rgb_p2  <= w_hit_p1 ? BOX_COLOR : r_rgb_p1;
            r_vld_p2  <= r_vld_p1;
            r_hs_p2   <= r_hs_p1;
            r_vs_p2   <= r_vs_p1;
            r_hcnt_p2 <= r_hcnt_p1;
            r_vcnt_p2 <= r_vcnt_p1;
        end
    end

    assign o_rgb     = r_rgb_p2;
    assign o_de      = r_vld_p2;
    assign o_hs      = r_hs_p2;
    assign o_vs      = r_vs_p2;
    assign o_hcount  = r_hcnt_p2;
    assign o_vcount  = r_vcnt_p2;
    assign o_box_cnt = r_box_cnt;

endmodule

// File: tb/tb_seg_box_overlay.sv
// Bench for seg_box_overlay. Two instances (THICK=1 and THICK=2) share one
// 64x32 video stream. Probe pixels with hand-computed expectations are
// queued per instance. A monitor matches them against the output position.
module tb_seg_box_overlay;
    localparam logic [23:0] RED = 24'hFF0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [23:0] rgb;
    logic        hs, vs, de;
    logic [191:0] hb1, hb2;
    logic [11:0] vl1, vr1, vl2, vr2;
    logic        en1, en2;

    logic [23:0] o_rgb1, o_rgb2;
    logic        o_hs1, o_vs1, o_de1, o_hs2, o_vs2, o_de2;
    logic [11:0] o_hc1, o_vc1, o_hc2, o_vc2;
    logic [3:0]  o_bc1, o_bc2;

    seg_box_overlay #(.IMG_WIDTH_LINE(64), .IMG_WIDTH_DATA(24), .THICK(1), .BOX_COLOR(RED)) dut1 (
        .pixelclk(clk), .reset_n(rst_n), .i_rgb(rgb), .i_hs(hs), .i_vs(vs), .i_de(de),
        .i_hbound(hb1), .i_vcount_l(vl1), .i_vcount_r(vr1), .i_overlay_en(en1),
        .o_rgb(o_rgb1), .o_hs(o_hs1), .o_vs(o_vs1), .o_de(o_de1),
        .o_hcount(o_hc1), .o_vcount(o_vc1), .o_box_cnt(o_bc1));

    seg_box_overlay #(.IMG_WIDTH_LINE(64), .IMG_WIDTH_DATA(24), .THICK(2), .BOX_COLOR(RED)) dut2 (
        .pixelclk(clk), .reset_n(rst_n), .i_rgb(rgb), .i_hs(hs), .i_vs(vs), .i_de(de),
        .i_hbound(hb2), .i_vcount_l(vl2), .i_vcount_r(vr2), .i_overlay_en(en2),
        .o_rgb(o_rgb2), .o_hs(o_hs2), .o_vs(o_vs2), .o_de(o_de2),
        .o_hcount(o_hc2), .o_vcount(o_vc2), .o_box_cnt(o_bc2));

    typedef struct {
        int   fr;
        int   h;
        int   v;
        logic red;
    } probe_t;

    probe_t q1[$];
    probe_t q2[$];
    int     checks = 0;
    int     errors = 0;
    int     ofr = -1;
    logic   ovs_q = 1'b0;
    logic   red_mode = 1'b0;
    int     red1 = 0, red2 = 0, blank_red1 = 0, blank_red2 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Passthrough pixel value: frame id, row and column packed into one word.
    function automatic logic [23:0] enc(input int fr, input int h, input int v);
        logic [7:0] f;
        logic [5:0] hh, vv;
        f  = fr[7:0];
        hh = h[5:0];
        vv = v[5:0];
        return {f, 2'b00, vv, 2'b00, hh};
    endfunction

    function automatic logic [191:0] put(input logic [191:0] hb, input int k, input int l, input int r);
        hb[24*(k-1) +: 12]    = 12'(l);
        hb[24*(k-1)+12 +: 12] = 12'(r);
        return hb;
    endfunction

    task automatic pr(input int d, input int fr, input int h, input int v, input logic red);
        probe_t p;
        p.fr = fr; p.h = h; p.v = v; p.red = red;
        if (d == 1) q1.push_back(p);
        else        q2.push_back(p);
    endtask

    // Scoreboard monitor: pops probes as the outputs reach their positions.
    always @(negedge clk) begin
        if (o_vs1 && !ovs_q) ofr++;
        ovs_q = o_vs1;
        if (o_de1) begin
            while (q1.size() > 0 && (q1[0].fr < ofr || (q1[0].fr == ofr &&
                   q1[0].v*64 + q1[0].h < int'(o_vc1)*64 + int'(o_hc1)))) begin
                chk($sformatf("d1 f%0d probe position missed", q1[0].fr),
                    {8'h0, o_vc1, o_hc1}, {8'h0, 12'(q1[0].v), 12'(q1[0].h)});
                void'(q1.pop_front());
            end
            if (q1.size() > 0 && q1[0].fr == ofr && q1[0].h == int'(o_hc1) && q1[0].v == int'(o_vc1)) begin
                chk($sformatf("d1 f%0d px(%0d,%0d)", ofr, q1[0].h, q1[0].v), 32'(o_rgb1),
                    32'(q1[0].red ? RED : enc(ofr, q1[0].h, q1[0].v)));
                void'(q1.pop_front());
            end
            if (red_mode && o_rgb1 == RED) red1++;
        end else if (o_rgb1 == RED) blank_red1++;
        if (o_de2) begin
            while (q2.size() > 0 && (q2[0].fr < ofr || (q2[0].fr == ofr &&
                   q2[0].v*64 + q2[0].h < int'(o_vc2)*64 + int'(o_hc2)))) begin
                chk($sformatf("d2 f%0d probe position missed", q2[0].fr),
                    {8'h0, o_vc2, o_hc2}, {8'h0, 12'(q2[0].v), 12'(q2[0].h)});
                void'(q2.pop_front());
            end
            if (q2.size() > 0 && q2[0].fr == ofr && q2[0].h == int'(o_hc2) && q2[0].v == int'(o_vc2)) begin
                chk($sformatf("d2 f%0d px(%0d,%0d)", ofr, q2[0].h, q2[0].v), 32'(o_rgb2),
                    32'(q2[0].red ? RED : enc(ofr, q2[0].h, q2[0].v)));
                void'(q2.pop_front());
            end
            if (red_mode && o_rgb2 == RED) red2++;
        end else if (o_rgb2 == RED) blank_red2++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " d1 video"}, {5'h0, o_rgb1, o_hs1, o_vs1, o_de1}, 32'h0);
        chk({tag, " d1 counts"}, {4'h0, o_hc1, o_vc1, o_bc1}, 32'h0);
        chk({tag, " d2 video"}, {5'h0, o_rgb2, o_hs2, o_vs2, o_de2}, 32'h0);
        chk({tag, " d2 counts"}, {4'h0, o_hc2, o_vc2, o_bc2}, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_zero("midframe reset");
        step();
        step();
        chk_zero("reset held");
        rst_n = 1'b1;
        red_mode = 1'b1;
    endtask

    // One 64x32 frame: vs pulse, short blank, 32 lines of 64 pixels plus 8 blank cycles.
    task automatic frame(input int fr, input int c1, input int c2);
        de = 1'b0; hs = 1'b0; rgb = '0;
        vs = 1'b1;
        step();
        chk($sformatf("f%0d vs lag 1", fr), 32'(o_vs1), 32'd0);
        step();
        chk($sformatf("f%0d vs lag 2", fr), 32'(o_vs1), 32'd1);
        vs = 1'b0;
        step();
        step();
        chk($sformatf("f%0d d1 box_cnt", fr), 32'(o_bc1), 32'(c1));
        chk($sformatf("f%0d d2 box_cnt", fr), 32'(o_bc2), 32'(c2));
        for (int line = 0; line < 32; line++) begin
            if (fr == 2 && line == 2) hb1 = put(hb1, 1, 40, 50);
            if (fr == 4 && line == 20) do_reset();
            for (int h = 0; h < 64; h++) begin
                de = 1'b1;
                rgb = enc(fr, h, line);
                step();
            end
            de = 1'b0;
            rgb = '0;
            for (int j = 0; j < 8; j++) begin
                hs = (j >= 2 && j <= 5);
                step();
                if (line == 0 && fr == 0)
                    chk($sformatf("hs lag j%0d", j), 32'(o_hs2), 32'((j >= 3 && j <= 6)));
            end
            hs = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rgb = '0; hs = 1'b0; vs = 1'b0; de = 1'b0;
        hb1 = '0; hb2 = '0; vl1 = '0; vr1 = '0; vl2 = '0; vr2 = '0; en1 = 1'b0; en2 = 1'b0;
        step(); step(); step();
        chk_zero("reset");
        rst_n = 1'b1;
        step(); step(); step(); step();

        // F0: single box, THICK=1 outline; THICK=2 on a 3x2 box fills it.
        hb1 = put('0, 1, 10, 20); vl1 = 12'd5; vr1 = 12'd15; en1 = 1'b1;
        hb2 = put('0, 1, 2, 4);   vl2 = 12'd0; vr2 = 12'd1;  en2 = 1'b1;
        pr(1,0,15,4,0); pr(1,0,9,5,0); pr(1,0,10,5,1); pr(1,0,15,5,1); pr(1,0,10,9,1);
        pr(1,0,15,10,0); pr(1,0,20,10,1); pr(1,0,21,10,0); pr(1,0,20,15,1); pr(1,0,15,16,0);
        pr(2,0,1,0,0); pr(2,0,2,0,1); pr(2,0,3,0,1); pr(2,0,5,0,0);
        pr(2,0,3,1,1); pr(2,0,4,1,1); pr(2,0,3,2,0);
        frame(0, 1, 1);

        // F1: eight disjoint boxes; THICK=2 box reaching the last column plus an invalid box.
        hb1 = '0;
        for (int k = 1; k <= 8; k++) hb1 = put(hb1, k, 4*(k-1), 4*(k-1)+2);
        vl1 = 12'd0; vr1 = 12'd31;
        hb2 = put(put('0, 1, 40, 63), 2, 30, 30); vl2 = 12'd0; vr2 = 12'd31;
        pr(1,1,1,0,1); pr(1,1,3,0,0); pr(1,1,28,0,1);
        pr(1,1,0,10,1); pr(1,1,1,10,0); pr(1,1,2,10,1); pr(1,1,3,10,0);
        pr(1,1,29,10,0); pr(1,1,30,10,1); pr(1,1,32,10,0);
        pr(1,1,1,31,1); pr(1,1,31,31,0);
        pr(2,1,50,0,1); pr(2,1,50,1,1); pr(2,1,50,2,0);
        pr(2,1,0,10,0); pr(2,1,30,10,0); pr(2,1,40,10,1); pr(2,1,41,10,1);
        pr(2,1,42,10,0); pr(2,1,61,10,0); pr(2,1,62,10,1); pr(2,1,63,10,1);
        frame(1, 8, 1);

        // F2: bounds change mid-frame must not affect this frame; overlay disabled on d2.
        hb1 = put(put('0, 1, 10, 20), 2, 30, 30); vl1 = 12'd5; vr1 = 12'd15;
        hb2 = put('0, 1, 2, 4); vl2 = 12'd0; vr2 = 12'd1; en2 = 1'b0;
        pr(1,2,10,5,1); pr(1,2,40,5,0); pr(1,2,30,10,0); pr(1,2,10,15,1);
        pr(2,2,2,0,0); pr(2,2,3,0,0); pr(2,2,4,1,0);
        frame(2, 1, 1);

        // F3: the mid-frame bounds now apply; d2 has bottom above top.
        vl2 = 12'd20; vr2 = 12'd10; en2 = 1'b1;
        pr(1,3,10,5,0); pr(1,3,40,5,1); pr(1,3,45,10,0); pr(1,3,50,10,1); pr(1,3,50,15,1);
        pr(2,3,2,10,0); pr(2,3,3,15,0); pr(2,3,2,20,0);
        frame(3, 1, 0);

        // F4: d1 disabled, d2 full-frame box; reset pulse at line 20.
        hb1 = put('0, 1, 10, 20); en1 = 1'b0;
        hb2 = put('0, 1, 0, 63); vl2 = 12'd0; vr2 = 12'd31;
        pr(1,4,10,5,0); pr(1,4,15,5,0); pr(1,4,10,9,0);
        pr(2,4,5,0,1); pr(2,4,5,5,0); pr(2,4,0,10,1); pr(2,4,63,10,1);
        frame(4, 1, 1);
        chk("d1 red after reset", 32'(red1), 32'd0);
        chk("d2 red after reset", 32'(red2), 32'd0);
        red_mode = 1'b0;

        // F5: next vs rise re-arms drawing.
        pr(1,5,10,5,0);
        pr(2,5,0,0,1); pr(2,5,5,5,0); pr(2,5,63,31,1);
        frame(5, 1, 1);

        for (int i = 0; i < 6; i++) step();
        chk("d1 probes left", 32'(q1.size()), 32'd0);
        chk("d2 probes left", 32'(q2.size()), 32'd0);
        chk("d1 red while de low", 32'(blank_red1), 32'd0);
        chk("d2 red while de low", 32'(blank_red2), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
